imem_responder: RTL and testbench

Instruction-memory responder for the 16-bit single-issue CPU. It serves fetch requests issued by the PC/fetch side with a fixed multi-cycle latency, allows one outstanding request at a time, and supports cancellation when a branch redirects the PC. A separate load port writes program images before and during simulation.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/imem_array.sv | 27 ++
 rtl/imem_responder.sv | 122 ++++++++++++
 tb/tb_imem_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch responder state encoding and
// the branch opcodes the fetch side decodes to raise a flush.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] OPCODE_B  = 4'hC;
  localparam logic [3:0] OPCODE_BR = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_e;

  // Everything the responder hands back with one instruction word.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] addr;
    logic              misalign;
  } rsp_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, combinational read, so a read in
// the same cycle as a write to the same word sees the old contents.
import cpu_pkg::*;

module imem_array #(
  parameter int DEPTH_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_W];

  // Program image writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with one outstanding request,
// flush-based cancellation and an unhandshaked load port for program images.
import cpu_pkg::*;

module imem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int          DEPTH_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic [WORD_W-1:0] rsp_addr,
  output logic              rsp_misalign,
  input  logic              flush,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data
);

  // State entered on an accept: single-cycle latency goes straight to RESP,
  // otherwise the counter covers the remaining LATENCY-1 wait cycles.
  localparam rsp_state_e START_ST  = (LATENCY > 1) ? ST_BUSY : ST_RESP;
  localparam logic [3:0] START_CNT = (LATENCY > 1) ? 4'(LATENCY - 1) : 4'd0;

  rsp_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  rsp_t              rsp_q, rsp_d;
  logic              accept;
  logic [WORD_W-1:0] rd_data;

  // Address bits above the array depth wrap; bit 0 of a load is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[WORD_W-1:DEPTH_W+1],
                              load_addr[WORD_W-1:DEPTH_W+1], load_addr[0]};

  imem_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr[DEPTH_W:1]),
    .wdata (load_data),
    .raddr (req_addr[DEPTH_W:1]),
    .rdata (rd_data)
  );

  assign req_ready = ((state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready)) & ~flush;
  assign accept    = req_valid & req_ready;

  // Next state, wait counter and response capture; flush overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;

    if (accept) begin
      rsp_d.data     = rd_data;
      rsp_d.addr     = req_addr;
      rsp_d.misalign = req_addr[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = START_ST;
          cnt_d   = START_CNT;
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            state_d = START_ST;
            cnt_d   = START_CNT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end
  end

  // State, counter and response register; reset drops any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_data     = rsp_q.data;
  assign rsp_addr     = rsp_q.addr;
  assign rsp_misalign = rsp_q.misalign;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=4 instance for most scenarios
// and a LATENCY=1 instance for single-cycle and reset-in-RESP cases.
import cpu_pkg::*;

module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [15:0] load_addr, load_data;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_misalign, flush;
  logic [15:0] req_addr, rsp_data, rsp_addr;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_misalign1, flush1;
  logic [15:0] req_addr1, rsp_data1, rsp_addr1;

  int total = 0;
  int bad   = 0;

  logic [15:0] model [4096];
  rsp_t exp4_q [$];
  rsp_t exp1_q [$];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(4), .DEPTH_W(12)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_misalign(rsp_misalign), .flush(flush),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.LATENCY(1), .DEPTH_W(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .rsp_addr(rsp_addr1), .rsp_misalign(rsp_misalign1), .flush(flush1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [15:0] a);
    rsp_t r;
    r.data     = model[a[12:1]];
    r.addr     = a;
    r.misalign = a[0];
    return r;
  endfunction

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    model[a[12:1]] = d;
    to_pos();
    load_en = 1'b0;
  endtask

  // Full LATENCY=4 transaction with rsp_ready held high, optionally with a
  // load to the same word in the accept cycle or in the first wait cycle.
  task automatic req_full(input logic [15:0] a, input bit ld_now, input logic [15:0] ld_now_d,
                          input bit ld_late, input logic [15:0] ld_late_d, input string tag);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    exp4_q.push_back(mk(a));
    if (ld_now) begin
      load_en = 1'b1; load_addr = a; load_data = ld_now_d;
      model[a[12:1]] = ld_now_d;
    end
    to_neg();
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    to_pos();
    req_valid = 1'b0;
    load_en   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ld_late && i == 0) begin
        load_en = 1'b1; load_addr = a; load_data = ld_late_d;
        model[a[12:1]] = ld_late_d;
      end
      to_neg();
      chk({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
      to_pos();
      load_en = 1'b0;
    end
    to_neg();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    to_pos();
  endtask

  // Scoreboards: every handshake on a response pops and compares one entry.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      total++;
      assert (exp4_q.size() > 0) else begin
        bad++;
        $error("FAIL sb4_unexpected obs=addr_%0h exp=no_response", rsp_addr);
      end
      if (exp4_q.size() > 0) begin
        rsp_t e;
        e = exp4_q.pop_front();
        chk("sb4_data", 32'(rsp_data), 32'(e.data));
        chk("sb4_addr", 32'(rsp_addr), 32'(e.addr));
        chk("sb4_misalign", 32'(rsp_misalign), 32'(e.misalign));
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid1 && rsp_ready1) begin
      total++;
      assert (exp1_q.size() > 0) else begin
        bad++;
        $error("FAIL sb1_unexpected obs=addr_%0h exp=no_response", rsp_addr1);
      end
      if (exp1_q.size() > 0) begin
        rsp_t e;
        e = exp1_q.pop_front();
        chk("sb1_data", 32'(rsp_data1), 32'(e.data));
        chk("sb1_addr", 32'(rsp_addr1), 32'(e.addr));
        chk("sb1_misalign", 32'(rsp_misalign1), 32'(e.misalign));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
    req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b0; flush1 = 1'b0;

    // Reset values, with program loads issued while reset is held.
    to_neg();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_addr", 32'(rsp_addr), 32'd0);
    chk("rst_misalign", 32'(rsp_misalign), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ready1", 32'(req_ready1), 32'd1);
    load_word(16'h0010, 16'hA123);
    load_word(16'h0012, 16'hB456);
    load_word(16'h0040, 16'h1111);
    rst_n = 1'b1;
    load_word(16'h0014, 16'hC0DE);

    // Basic fetch, latency 4.
    req_full(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, "basic");

    // Stall in RESP, then back-to-back accept in the release cycle.
    req_valid = 1'b1; req_addr = 16'h0014; rsp_ready = 1'b0;
    exp4_q.push_back(mk(16'h0014));
    to_pos();
    req_valid = 1'b0;
    to_pos(); to_pos(); to_pos();
    req_valid = 1'b1; req_addr = 16'h0012;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'hC0DE);
      chk("hold_addr", 32'(rsp_addr), 32'h0014);
      chk("hold_ready", 32'(req_ready), 32'd0);
      to_pos();
    end
    rsp_ready = 1'b1;
    exp4_q.push_back(mk(16'h0012));
    to_neg();
    chk("b2b_ready", 32'(req_ready), 32'd1);
    to_pos();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("b2b_wait_valid", 32'(rsp_valid), 32'd0);
      to_pos();
    end
    to_neg();
    chk("b2b_valid", 32'(rsp_valid), 32'd1);
    to_pos();

    // Flush two cycles after accept: the response never appears.
    req_valid = 1'b1; req_addr = 16'h0010;
    to_pos();
    req_valid = 1'b0;
    to_pos();
    flush = 1'b1;
    to_neg();
    chk("flush_busy_ready", 32'(req_ready), 32'd0);
    to_pos();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("flush_busy_valid", 32'(rsp_valid), 32'd0);
      chk("flush_busy_idle", 32'(req_ready), 32'd1);
      to_pos();
    end

    // Flush together with a request in IDLE: not accepted.
    flush = 1'b1; req_valid = 1'b1; req_addr = 16'h0010;
    to_neg();
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    to_pos();
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("flush_req_valid", 32'(rsp_valid), 32'd0);
      chk("flush_req_idle", 32'(req_ready), 32'd1);
      to_pos();
    end

    // Flush while the response is waiting in RESP.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'h0012;
    to_pos();
    req_valid = 1'b0;
    to_pos(); to_pos(); to_pos();
    flush = 1'b1;
    to_neg();
    chk("flush_resp_before", 32'(rsp_valid), 32'd1);
    to_pos();
    flush = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("flush_resp_valid", 32'(rsp_valid), 32'd0);
      chk("flush_resp_idle", 32'(req_ready), 32'd1);
      to_pos();
    end

    // Misaligned, out-of-range address wraps to word 0x008.
    req_full(16'h2011, 1'b0, 16'h0, 1'b0, 16'h0, "misalign");

    // Read-before-write in the accept cycle, then a load during BUSY that
    // must not disturb the in-flight response, then a read of that load.
    req_full(16'h0040, 1'b1, 16'h5555, 1'b0, 16'h0, "rbw");
    req_full(16'h0040, 1'b0, 16'h0, 1'b1, 16'h7777, "after_load");
    req_full(16'h0041, 1'b0, 16'h0, 1'b0, 16'h0, "late_load");

    // Asynchronous reset while BUSY.
    req_valid = 1'b1; req_addr = 16'h0012; rsp_ready = 1'b1;
    to_pos();
    req_valid = 1'b0;
    to_neg();
    chk("rstbusy_pre_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy_valid", 32'(rsp_valid), 32'd0);
    chk("rstbusy_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    to_pos();
    req_full(16'h0012, 1'b0, 16'h0, 1'b0, 16'h0, "post_rst");

    // LATENCY=1: back-to-back accepts give one response per cycle.
    req_valid1 = 1'b1; req_addr1 = 16'h0010; rsp_ready1 = 1'b1;
    exp1_q.push_back(mk(16'h0010));
    to_neg();
    chk("l1_ready", 32'(req_ready1), 32'd1);
    to_pos();
    req_addr1 = 16'h0012;
    exp1_q.push_back(mk(16'h0012));
    to_neg();
    chk("l1_valid_a", 32'(rsp_valid1), 32'd1);
    chk("l1_b2b_ready", 32'(req_ready1), 32'd1);
    to_pos();
    req_valid1 = 1'b0;
    to_neg();
    chk("l1_valid_b", 32'(rsp_valid1), 32'd1);
    to_pos();
    to_neg();
    chk("l1_idle_valid", 32'(rsp_valid1), 32'd0);
    to_pos();

    // LATENCY=1: asynchronous reset while a response is held in RESP.
    rsp_ready1 = 1'b0; req_valid1 = 1'b1; req_addr1 = 16'h0014;
    to_pos();
    req_valid1 = 1'b0;
    to_neg();
    chk("l1_rst_pre_valid", 32'(rsp_valid1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("l1_rst_valid", 32'(rsp_valid1), 32'd0);
    chk("l1_rst_ready", 32'(req_ready1), 32'd1);
    chk("l1_rst_data", 32'(rsp_data1), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    to_pos();
    rsp_ready1 = 1'b1; req_valid1 = 1'b1; req_addr1 = 16'h0040;
    exp1_q.push_back(mk(16'h0040));
    to_pos();
    req_valid1 = 1'b0;
    to_neg();
    chk("l1_post_rst_valid", 32'(rsp_valid1), 32'd1);
    to_pos();
    to_pos();

    chk("sb4_drained", 32'(exp4_q.size()), 32'd0);
    chk("sb1_drained", 32'(exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
